// File: rtl/hps_status.sv
// hps_status: read-only status slave on the HPS lightweight bridge (turn timing, turn count, sticky events, IRQ).
// Define HPS_STATUS_STALL_EN to build the STALLED detector; otherwise STATUS bit 2 reads 0.
module hps_status #(
  parameter int W_ADDR_WIDTH = 2,
  parameter int W_DATA_WIDTH = 32,
  parameter int PERIOD_WIDTH = 28,
  parameter int STALL_CYCLES = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    turn_tick,
  input  logic                    frame_done,
  input  logic [W_ADDR_WIDTH-1:0] r_addr,
  input  logic                    read,
  output logic [W_DATA_WIDTH-1:0] r_data,
  output logic                    r_data_valid,
  output logic                    status_IRQ
);

  localparam logic [PERIOD_WIDTH-1:0] CUR_MAX   = '1;
  localparam logic [15:0]             STATUS_ID = 16'h4C53;

  logic                    tick_s1_q, tick_s2_q, tick_prev_q;
  logic                    detect;
  logic [PERIOD_WIDTH-1:0] cur_q, cur_d;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic                    arm_q, period_valid_q;
  logic [31:0]             turn_count_q;
  logic                    tick_pend_q, frame_pend_q;
  logic                    stalled;
  logic                    status_clr;
  logic [W_DATA_WIDTH-1:0] rd_mux;
  logic [W_DATA_WIDTH-1:0] r_data_q;
  logic                    r_data_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_s1_q   <= 1'b0;
      tick_s2_q   <= 1'b0;
      tick_prev_q <= 1'b0;
    end else begin
      tick_s1_q   <= turn_tick;
      tick_s2_q   <= tick_s1_q;
      tick_prev_q <= tick_s2_q;
    end
  end

  // One detection per high-to-low transition of the synchronized hall level.
  assign detect = tick_prev_q & ~tick_s2_q;

  always_comb begin
    cur_d = cur_q;
    if (detect) begin
      cur_d = PERIOD_WIDTH'(1);
    end else if (cur_q != CUR_MAX) begin
      cur_d = cur_q + PERIOD_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q          <= '0;
      period_q       <= '0;
      arm_q          <= 1'b0;
      period_valid_q <= 1'b0;
      turn_count_q   <= '0;
    end else begin
      cur_q <= cur_d;
      if (detect) begin
        arm_q        <= 1'b1;
        turn_count_q <= turn_count_q + 32'd1;
        // The first detection only opens the measurement window.
        if (arm_q) begin
          period_q       <= cur_q;
          period_valid_q <= 1'b1;
        end
      end
    end
  end

  assign status_clr = read && (r_addr == W_ADDR_WIDTH'(0));

  // Set has priority over the read-to-clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_pend_q  <= 1'b0;
      frame_pend_q <= 1'b0;
    end else begin
      if (detect) begin
        tick_pend_q <= 1'b1;
      end else if (status_clr) begin
        tick_pend_q <= 1'b0;
      end
      if (frame_done) begin
        frame_pend_q <= 1'b1;
      end else if (status_clr) begin
        frame_pend_q <= 1'b0;
      end
    end
  end

`ifdef HPS_STATUS_STALL_EN
  localparam logic [PERIOD_WIDTH-1:0] STALL_LIMIT = PERIOD_WIDTH'(STALL_CYCLES);

  logic stalled_q;

  // Compared against the next count so STALLED tracks CUR_COUNT in the same read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stalled_q <= 1'b0;
    end else if (detect) begin
      stalled_q <= 1'b0;
    end else if (cur_d >= STALL_LIMIT) begin
      stalled_q <= 1'b1;
    end
  end

  assign stalled = stalled_q;
`else
  assign stalled = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (r_addr)
      W_ADDR_WIDTH'(0): begin
        rd_mux[3:0]   = {period_valid_q, stalled, frame_pend_q, tick_pend_q};
        rd_mux[31:16] = STATUS_ID;
      end
      W_ADDR_WIDTH'(1): rd_mux = W_DATA_WIDTH'(period_q);
      W_ADDR_WIDTH'(2): rd_mux = W_DATA_WIDTH'(turn_count_q);
      W_ADDR_WIDTH'(3): rd_mux = W_DATA_WIDTH'(cur_q);
      default:          rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q       <= '0;
      r_data_valid_q <= 1'b0;
    end else begin
      r_data_valid_q <= read;
      if (read) begin
        r_data_q <= rd_mux;
      end
    end
  end

  assign r_data       = r_data_q;
  assign r_data_valid = r_data_valid_q;
  assign status_IRQ   = tick_pend_q | frame_pend_q;

endmodule
